// File: rtl/irq_enc_pkg.sv
// Shared constants and types for the 8-to-3 interrupt encoder.
// Vectors use ascending bit order: element 0 is the leftmost bit.
package irq_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef logic [0:CODE_W-1] code_t;
    typedef logic [0:N_REQ-1]  req_vec_t;

    // Decode a line index to a one-hot vector, gated by en.
    function automatic req_vec_t onehot(input code_t idx, input logic en);
        req_vec_t r;
        r = '0;
        if (en) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational 8-to-3 priority encoder with a rotating start index.
// Scans upward from start, wrapping 7->0; the first set line wins.
module priority_encoder_8to3
    import irq_enc_pkg::*;
(
    input  req_vec_t vec,
    input  code_t    start,
    output logic     found,
    output code_t    index
);

    code_t idx;

    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // 3-bit addition wraps naturally from 7 back to 0.
            idx = start + code_t'(k);
            if (!found && vec[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Sticky-pending interrupt encoder with registered code/valid handshake.
// Define IRQ_ENC_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module irq_encoder_8to3
    import irq_enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] req,
    input  logic       en,
    input  logic       ack,
    output logic       valid,
    output logic [0:2] code,
    output logic [0:7] pending
);

    req_vec_t pending_q, pending_d;
    logic     valid_q, valid_d;
    code_t    code_q, code_d;

    logic     accept;
    logic     update;
    req_vec_t clr;
    code_t    start_idx;
    logic     sel_found;
    code_t    sel_idx;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    code_t    ptr_q, ptr_d;
`endif

    priority_encoder_8to3 u_prio (
        .vec   (pending_d),
        .start (start_idx),
        .found (sel_found),
        .index (sel_idx)
    );

    always_comb begin
        accept    = valid_q & ack;
        clr       = onehot(code_q, accept);
        // A fresh request on the line being cleared keeps it pending.
        pending_d = (pending_q & ~clr) | req;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
        // Search uses the already-advanced pointer so the acked line goes last.
        ptr_d     = accept ? code_q + code_t'(1) : ptr_q;
        start_idx = ptr_d;
`else
        start_idx = '0;
`endif

        update  = ~valid_q | ack;
        valid_d = valid_q;
        code_d  = code_q;
        if (update) begin
            if (en && sel_found) begin
                valid_d = 1'b1;
                code_d  = sel_idx;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
`ifdef IRQ_ENC_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
`ifdef IRQ_ENC_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign valid   = valid_q;
    assign code    = code_q;
    assign pending = pending_q;

endmodule
